// File: rtl/float_cmp_arbiter.sv
// float_cmp_arbiter: round-robin front end that time-shares one float
// comparator among N_REQ requesters. One issue per cycle, at most one
// compare outstanding per requester, and responses come back tagged with
// the requester id in grant order. The parameters must satisfy
// 2**ID_W >= N_REQ and CMP_LAT >= 1.
module float_cmp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int CMP_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [31:0]           cmp_a,
  output logic [31:0]           cmp_b,
  output logic                  cmp_valid,
  input  logic                  cmp_is_higher,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_is_higher,
  output logic                  busy
);

  logic [ID_W-1:0]  ptr;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] rsp_clr;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  // id of the compare currently presented on cmp_a/cmp_b
  logic [ID_W-1:0]  issue_id;
  // tag pipeline lines the issued id up with the comparator result
  logic [CMP_LAT-1:0] tag_v;
  logic [ID_W-1:0]    tag_id [CMP_LAT];

  assign eligible = req & ~pending;
  assign busy     = |pending;
  // grant is forced low while reset is asserted so gnt reads 0 immediately
  assign gnt      = reset_n ? grant : '0;

  // Round-robin pick: first eligible at or above ptr, then wrap to below ptr.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && eligible[i] && (i >= int'(ptr))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = ID_W'(i);
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && eligible[i] && (i < int'(ptr))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = ID_W'(i);
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
      end
    end
  end

  // Decode the retiring tag into a one-hot pending clear.
  always_comb begin
    rsp_clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_v[CMP_LAT-1] && (tag_id[CMP_LAT-1] == ID_W'(i))) rsp_clr[i] = 1'b1;
    end
  end

  // Issue side: pointer advance, operand launch and pending bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      pending   <= '0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_valid <= 1'b0;
      issue_id  <= '0;
    end else begin
      cmp_valid <= grant_any;
      pending   <= (pending | grant) & ~rsp_clr;
      if (grant_any) begin
        cmp_a    <= sel_a;
        cmp_b    <= sel_b;
        issue_id <= grant_id;
        ptr      <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // Tag shift pipeline covering the comparator latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int s = 0; s < CMP_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= cmp_valid;
      tag_id[0] <= issue_id;
      for (int s = 1; s < CMP_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // Response capture: the retiring tag qualifies the comparator result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_is_higher <= 1'b0;
    end else begin
      rsp_valid <= tag_v[CMP_LAT-1];
      if (tag_v[CMP_LAT-1]) begin
        rsp_id        <= tag_id[CMP_LAT-1];
        rsp_is_higher <= cmp_is_higher;
      end
    end
  end

endmodule

// File: tb/tb_float_cmp_arbiter.sv
// Bench for float_cmp_arbiter: one instance at CMP_LAT=1, one at CMP_LAT=3,
// each fed by a behavioural comparator. Directed stimulus pushes expected
// responses; per-instance monitors pop and compare on rsp_valid.
module tb_float_cmp_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int id; bit hi; int cyc; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  logic [3:0]   req1, req2;
  logic [127:0] req_a1, req_b1, req_a2, req_b2;
  logic [3:0]   gnt1, gnt2;
  logic [31:0]  cmp_a1, cmp_b1, cmp_a2, cmp_b2;
  logic         cmp_valid1, cmp_valid2;
  logic         cmp_hi1 = 1'b0;
  logic [2:0]   hp2 = '0;
  logic         rsp_valid1, rsp_valid2;
  logic [1:0]   rsp_id1, rsp_id2;
  logic         rsp_hi1, rsp_hi2;
  logic         busy1, busy2;
  logic [3:0]   exp_hi1, exp_hi2;

  float_cmp_arbiter #(.N_REQ(4), .ID_W(2), .CMP_LAT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req1), .req_a(req_a1), .req_b(req_b1),
    .gnt(gnt1), .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_valid(cmp_valid1),
    .cmp_is_higher(cmp_hi1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1),
    .rsp_is_higher(rsp_hi1), .busy(busy1));

  float_cmp_arbiter #(.N_REQ(4), .ID_W(2), .CMP_LAT(3)) dut2 (
    .clock(clock), .reset_n(reset_n), .req(req2), .req_a(req_a2), .req_b(req_b2),
    .gnt(gnt2), .cmp_a(cmp_a2), .cmp_b(cmp_b2), .cmp_valid(cmp_valid2),
    .cmp_is_higher(hp2[2]), .rsp_valid(rsp_valid2), .rsp_id(rsp_id2),
    .rsp_is_higher(rsp_hi2), .busy(busy2));

  function automatic bit fgt(logic [31:0] a, logic [31:0] b);
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  // behavioural comparators with latency 1 and 3
  always @(posedge clock) begin
    cmp_hi1 <= fgt(cmp_a1, cmp_b1);
    hp2     <= {hp2[1:0], fgt(cmp_a2, cmp_b2)};
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_op(int inst, int i, logic [31:0] a, logic [31:0] b, bit hi);
    if (inst == 0) begin
      req_a1[32*i +: 32] = a; req_b1[32*i +: 32] = b; exp_hi1[i] = hi;
    end else begin
      req_a2[32*i +: 32] = a; req_b2[32*i +: 32] = b; exp_hi2[i] = hi;
    end
  endtask

  task automatic step(int inst, logic [3:0] r, logic [3:0] eg);
    exp_t e;
    int id;
    @(negedge clock);
    if (inst == 0) req1 = r; else req2 = r;
    #1;
    check($sformatf("gnt%0d", inst), 32'(inst == 0 ? gnt1 : gnt2), 32'(eg));
    if (eg != 4'b0000) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) id = i;
      e.id  = id;
      e.hi  = (inst == 0) ? exp_hi1[id] : exp_hi2[id];
      e.cyc = cyc + 2 + ((inst == 0) ? 1 : 3);
      if (inst == 0) q1.push_back(e); else q2.push_back(e);
    end
  endtask

  task automatic pop_check(int inst);
    exp_t e;
    if ((inst == 0 && q1.size() == 0) || (inst == 1 && q2.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp%0d_unexpected: got rsp_valid=1 expected no response (cycle %0d)", inst, cyc);
    end else begin
      e = (inst == 0) ? q1.pop_front() : q2.pop_front();
      check($sformatf("rsp%0d_id", inst), 32'(inst == 0 ? rsp_id1 : rsp_id2), 32'(e.id));
      check($sformatf("rsp%0d_hi", inst), 32'(inst == 0 ? rsp_hi1 : rsp_hi2), 32'(e.hi));
      check($sformatf("rsp%0d_cycle", inst), 32'(cyc), 32'(e.cyc));
    end
  endtask

  // monitors
  always @(negedge clock) if (rsp_valid1) pop_check(0);
  always @(negedge clock) if (rsp_valid2) pop_check(1);

  task automatic check_reset_outs(string tag);
    check({tag, "_cmp_valid"}, 32'(cmp_valid1), 0);
    check({tag, "_cmp_a"}, cmp_a1, 0);
    check({tag, "_cmp_b"}, cmp_b1, 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid1), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id1), 0);
    check({tag, "_rsp_hi"}, 32'(rsp_hi1), 0);
    check({tag, "_gnt"}, 32'(gnt1), 0);
    check({tag, "_busy"}, 32'(busy1), 0);
  endtask

  initial begin
    req1 = '0; req2 = '0;
    req_a1 = '0; req_b1 = '0; req_a2 = '0; req_b2 = '0;
    exp_hi1 = '0; exp_hi2 = '0;

    // reset values, with requests present to show gnt is held low
    repeat (2) @(negedge clock);
    req1 = 4'b1111;
    #1;
    check_reset_outs("rst");
    check("rst2_cmp_valid", 32'(cmp_valid2), 0);
    check("rst2_busy", 32'(busy2), 0);
    req1 = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;

    // single compare at default latency
    set_op(0, 0, 32'hBE200000, 32'h3F800000, 1'b0);
    step(0, 4'b0001, 4'b0001);
    step(0, 4'b0000, 4'b0000);
    check("single_cmp_valid", 32'(cmp_valid1), 1);
    check("single_cmp_a", cmp_a1, 32'hBE200000);
    check("single_cmp_b", cmp_b1, 32'h3F800000);
    check("single_busy_t1", 32'(busy1), 1);
    step(0, 4'b0000, 4'b0000);
    check("single_busy_t2", 32'(busy1), 1);
    step(0, 4'b0000, 4'b0000);
    check("single_busy_t3", 32'(busy1), 0);
    step(0, 4'b0000, 4'b0000);

    // back-to-back pipelining, pointer now at 1
    set_op(0, 1, 32'h40000000, 32'h3F800000, 1'b1);
    set_op(0, 2, 32'h00000000, 32'h3F800000, 1'b0);
    step(0, 4'b0110, 4'b0010);
    step(0, 4'b0100, 4'b0100);
    check("b2b_cmp_a", cmp_a1, 32'h40000000);
    repeat (4) step(0, 4'b0000, 4'b0000);

    // pending mask: req[3] held, re-granted on its response cycle
    set_op(0, 3, 32'hBF800000, 32'hC0000000, 1'b1);
    step(0, 4'b1000, 4'b1000);
    step(0, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b1000);
    repeat (5) step(0, 4'b0000, 4'b0000);

    // round-robin fairness with all requesters held
    set_op(0, 0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(0, 1, 32'h40400000, 32'h40000000, 1'b1);
    set_op(0, 2, 32'h80000000, 32'h00000000, 1'b0);
    set_op(0, 3, 32'h7F7FFFFF, 32'hFF7FFFFF, 1'b1);
    for (int k = 0; k < 8; k++) step(0, 4'b1111, 4'(1 << (k % 4)));
    repeat (5) step(0, 4'b0000, 4'b0000);

    // reset mid-flight: grant 0 moves pointer to 1, reset drops it all
    set_op(0, 0, 32'h3F800000, 32'h00000000, 1'b1);
    step(0, 4'b0001, 4'b0001);
    @(negedge clock);
    req1 = 4'b0000;
    reset_n = 1'b0;
    q1.delete();
    #1;
    check_reset_outs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) step(0, 4'b0000, 4'b0000);
    step(0, 4'b0011, 4'b0001);
    repeat (4) step(0, 4'b0000, 4'b0000);

    // latency 3 instance: single grant, then four back-to-back
    set_op(1, 0, 32'h3F800000, 32'hBF800000, 1'b1);
    set_op(1, 1, 32'h00800000, 32'h00000001, 1'b1);
    set_op(1, 2, 32'hC1200000, 32'hC0A00000, 1'b0);
    set_op(1, 3, 32'h41200000, 32'h41200000, 1'b0);
    step(1, 4'b0001, 4'b0001);
    repeat (6) step(1, 4'b0000, 4'b0000);
    step(1, 4'b1111, 4'b0010);
    step(1, 4'b1111, 4'b0100);
    step(1, 4'b1111, 4'b1000);
    step(1, 4'b1111, 4'b0001);
    step(1, 4'b0000, 4'b0000);
    repeat (8) step(1, 4'b0000, 4'b0000);

    check("q1_drained", 32'(q1.size()), 0);
    check("q2_drained", 32'(q2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_cmp_arbiter.md
Name: float_cmp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Float_comparator instance between N_REQ requesters.
- Each requester presents an operand pair (a, b). The block grants one requester per cycle and drives the shared comparator.
- It tracks in-flight compares through the comparator's fixed latency and returns each is_higher result tagged with the requester id.
- It sits between the classifier/threshold stages and the single comparator datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= N_REQ
- CMP_LAT, 1, comparator latency in clock cycles from cmp_a/cmp_b/cmp_valid registered to cmp_is_higher valid (>=1)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request; held high with stable operands until gnt
- req_a  in  32*N_REQ  operand a, IEEE-754 single; requester i at bits [32*i+31:32*i]
- req_b  in  32*N_REQ  operand b, same packing as req_a
- gnt  out  N_REQ  one-hot grant, combinational, high for exactly one cycle per accepted request
- cmp_a  out  32  operand a to comparator (registered)
- cmp_b  out  32  operand b to comparator (registered)
- cmp_valid  out  1  cmp_a/cmp_b carry a live compare (registered)
- cmp_is_higher  in  1  comparator result (a > b), valid CMP_LAT cycles after cmp_valid
- rsp_valid  out  1  response strobe, one cycle per compare (registered)
- rsp_id  out  ID_W  requester index of the response
- rsp_is_higher  out  1  captured comparator result
- busy  out  1  any compare in flight (OR of pending bits)

Behaviour:
- Reset (async assert, sync release): cmp_a=0, cmp_b=0, cmp_valid=0, rsp_valid=0, rsp_id=0, rsp_is_higher=0, gnt=0, busy=0. The pending mask, latency pipeline and round-robin pointer are cleared (pointer=0). In-flight compares are dropped and produce no response.
- Eligibility: requester i is eligible when req[i]=1 and pending[i]=0. At most one outstanding compare per requester.
- Arbitration, cycle t:
  - Scan from pointer upward (mod N_REQ) and grant the first eligible requester i: gnt[i]=1.
  - If nothing is eligible, gnt=0.
  - On a grant, the pointer becomes (i+1) mod N_REQ at the end of t. With no grant, the pointer holds.
- Issue: at the edge ending t, cmp_a<=req_a[i], cmp_b<=req_b[i], cmp_valid<=1, pending[i]<=1. A tag {valid, id=i} enters a CMP_LAT-deep shift pipeline. With no grant, cmp_valid<=0; cmp_a/cmp_b hold.
- Throughput: one issue per cycle, back-to-back across different requesters.
- Response:
  - The tag leaving the pipeline in cycle t+1+CMP_LAT qualifies cmp_is_higher.
  - At that edge, rsp_valid<=1, rsp_id<=id, rsp_is_higher<=cmp_is_higher, pending[id]<=0.
  - Grant-to-response latency: rsp_valid is visible in cycle t+2+CMP_LAT (t+3 at default).
  - Responses return in grant order.
- Re-request: requester i is eligible again in the cycle its rsp_valid is high. Re-grant in that cycle is legal.
- Simultaneous set/clear of pending on the same requester cannot occur, since a pending requester is ineligible.
- Holding req high after gnt with pending set has no effect; the requester is not re-granted.
- Dropping req before gnt withdraws the request with no side effect.
- busy = |pending, combinational from registers.
- Any reset_n assertion mid-operation: all outputs go to reset values immediately (asynchronously).

Test Plan:
- Reset mid-flight: grant req[0], assert reset_n=0 in cycle t+1 -> all outputs 0 immediately; no rsp_valid after release; pointer=0, so the next grant goes to requester 0.
- Single compare, default CMP_LAT=1: req[0]=1, a=0xBE200000 (-0.15625), b=0x3F800000 (1.0) at t -> gnt=4'b0001 at t; cmp_valid=1 and cmp_a=0xBE200000 at t+1; rsp_valid=1, rsp_id=0, rsp_is_higher=0 at t+3; busy high t+1..t+2.
- Round-robin fairness: req=4'b1111 held, each requester re-raises after its response -> grant order 0,1,2,3,0,1... with one gnt per cycle; no requester granted twice within 4 consecutive grants.
- Back-to-back pipelining: req[1] a=0x40000000 (2.0) vs b=0x3F800000; req[2] a=0x00000000 vs b=0x3F800000, both asserted at t -> gnt[1] at t, gnt[2] at t+1; responses at t+3 (id=1, is_higher=1) and t+4 (id=2, is_higher=0).
- Pending mask: req[3] held high continuously -> granted at t; gnt[3]=0 in t+1..t+2; re-granted in t+3, coincident with its rsp_valid.
- Latency parameter CMP_LAT=3 with a model comparator: single grant at t -> rsp_valid exactly at t+5; 4 requesters issued back-to-back -> 4 consecutive rsp_valid cycles in grant order with correct ids.
